// File: rtl/mult32x32_ctrl.sv
// Sequencer for the 32x32 shift-add multiplier datapath: one clear step, then
// four half-word partial-product steps. Optional build macro MULT_CTRL_ZERO_SKIP_EN.
module mult32x32_ctrl #(
    parameter int OPW = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] a_in,
    input  logic [OPW-1:0] b_in,
    output logic           busy,
    output logic           done,
    output logic [OPW-1:0] a,
    output logic [OPW-1:0] b,
    output logic           a_sel,
    output logic           b_sel,
    output logic [1:0]     shift_sel,
    output logic           upd_prod,
    output logic           clr_prod
);

    localparam int HW = OPW / 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        S00  = 3'd2,
        S01  = 3'd3,
        S10  = 3'd4,
        S11  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [3:0]     step_req;

    // Bit k of step_req marks step k (S00, S01, S10, S11) as needed.
`ifdef MULT_CTRL_ZERO_SKIP_EN
    logic a_lo_nz, a_hi_nz, b_lo_nz, b_hi_nz;
    assign a_lo_nz  = |a_q[HW-1:0];
    assign a_hi_nz  = |a_q[OPW-1:HW];
    assign b_lo_nz  = |b_q[HW-1:0];
    assign b_hi_nz  = |b_q[OPW-1:HW];
    assign step_req = {a_hi_nz & b_hi_nz, a_hi_nz & b_lo_nz,
                       a_lo_nz & b_hi_nz, a_lo_nz & b_lo_nz};
`else
    assign step_req = 4'b1111;
`endif

    function automatic state_t first_step(input logic [3:0] req);
        if (req[0])      return S00;
        else if (req[1]) return S01;
        else if (req[2]) return S10;
        else if (req[3]) return S11;
        else             return IDLE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = 2'b00;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = CLR;
                end
            end
            CLR: begin
                clr_prod = 1'b1;
                state_d  = first_step(step_req);
            end
            S00: begin
                upd_prod = 1'b1;
                state_d  = first_step(step_req & 4'b1110);
            end
            S01: begin
                upd_prod  = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b01;
                state_d   = first_step(step_req & 4'b1100);
            end
            S10: begin
                upd_prod  = 1'b1;
                a_sel     = 1'b1;
                shift_sel = 2'b01;
                state_d   = first_step(step_req & 4'b1000);
            end
            S11: begin
                upd_prod  = 1'b1;
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b10;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // done marks the edge on which the last partial product was accumulated.
    assign busy_d = (state_d != IDLE);
    assign done_d = (state_q != IDLE) && (state_d == IDLE);

    assign busy = busy_q;
    assign done = done_q;
    assign a    = a_q;
    assign b    = b_q;

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Directed bench for mult32x32_ctrl with a behavioural shift-add datapath
// attached, so products can be checked against hand-computed values.
module tb_mult32x32_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] a, b;
    logic        a_sel, b_sel;
    logic [1:0]  shift_sel;
    logic        upd_prod, clr_prod;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult32x32_ctrl #(.OPW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .a         (a),
        .b         (b),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .shift_sel (shift_sel),
        .upd_prod  (upd_prod),
        .clr_prod  (clr_prod)
    );

    // Behavioural datapath: clear only honoured while upd_prod is low.
    logic [63:0] prod;
    logic [63:0] pp;
    always_comb begin
        pp = 64'(a_sel ? a[31:16] : a[15:0]) * 64'(b_sel ? b[31:16] : b[15:0]);
        case (shift_sel)
            2'b01:   pp = pp << 16;
            2'b10:   pp = pp << 32;
            default: pp = pp;
        endcase
    end
    always_ff @(posedge clk) begin
        if (upd_prod)      prod <= prod + pp;
        else if (clr_prod) prod <= 64'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges from the accepting edge up to and including the done-setting edge.
    function automatic int lat(input logic [31:0] av, input logic [31:0] bv);
`ifdef MULT_CTRL_ZERO_SKIP_EN
        int n;
        n = 2;
        if (av[15:0]  != 0 && bv[15:0]  != 0) n++;
        if (av[15:0]  != 0 && bv[31:16] != 0) n++;
        if (av[31:16] != 0 && bv[15:0]  != 0) n++;
        if (av[31:16] != 0 && bv[31:16] != 0) n++;
        return n;
`else
        return 6;
`endif
    endfunction

    task automatic do_mult(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [63:0] ep, input bit hold, input bit poke, input bit trace);
        int edges;
        int busy_cnt;
        logic [5:0] seq [5];
        seq = '{6'h20, 6'h10, 6'h15, 6'h19, 6'h1E};
        start = 1'b1;
        a_in  = av;
        b_in  = bv;
        step();
        if (!hold) start = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (trace && busy_cnt < 5)
                chk({tag, " strobes"}, 64'({clr_prod, upd_prod, a_sel, b_sel, shift_sel}),
                    64'(seq[busy_cnt]));
            if (busy) busy_cnt++;
            if (poke) begin
                start = (edges == 2 || edges == 3);
                a_in  = 32'h5;
            end
            step();
            edges++;
        end
        $display("txn %s: a=0x%08h b=0x%08h prod=0x%016h edges=%0d busy_cycles=%0d",
                 tag, av, bv, prod, edges, busy_cnt);
        chk({tag, " latency"}, 64'(edges), 64'(lat(av, bv)));
        chk({tag, " product"}, prod, ep);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat(av, bv) - 1));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " a_held"}, 64'(a), 64'(av));
        chk({tag, " b_held"}, 64'(b), 64'(bv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk("reset outputs", 64'({busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod}), 64'd0);
        chk("reset a", 64'(a), 64'd0);
        chk("reset b", 64'(b), 64'd0);
        reset = 1'b1;
        step();

        // Abort in S01 with an asynchronous reset.
        start = 1'b1;
        a_in  = 32'h11112222;
        b_in  = 32'h33334444;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre-abort in S01", 64'({upd_prod, b_sel, shift_sel}), 64'b1101);
        #2 reset = 1'b0;
        #1;
        $display("txn abort: reset asserted mid-operation");
        chk("abort outputs", 64'({busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod}), 64'd0);
        chk("abort a", 64'(a), 64'd0);
        chk("abort b", 64'(b), 64'd0);
        step();
        step();
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dcnt++;
        end
        chk("abort no done", 64'(dcnt), 64'd0);
        chk("abort idle busy", 64'(busy), 64'd0);

        do_mult("basic",  32'h00010002, 32'h00030004, 64'h00000003000A0008, 1'b0, 1'b0, 1'b1);
        do_mult("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, 1'b0, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        do_mult("busy_poke",  32'h12345678, 32'h00000009, 64'h00000000A3D70A38, 1'b0, 1'b1, 1'b0);
        do_mult("done_start", 32'h00000003, 32'h00000004, 64'h000000000000000C, 1'b0, 1'b0, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) dcnt++;
        end
        chk("no extra done", 64'(dcnt), 64'd0);

        // Start held high: back-to-back runs, each starting on the previous done cycle.
        do_mult("b2b_0", 32'h00000002, 32'h00000003, 64'h0000000000000006, 1'b1, 1'b0, 1'b0);
        do_mult("b2b_1", 32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b1, 1'b0, 1'b0);
        do_mult("b2b_2", 32'h00000007, 32'h00000000, 64'h0000000000000000, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step();

        do_mult("small",    32'h00000005, 32'h00000007, 64'h0000000000000023, 1'b0, 1'b0, 1'b0);
        do_mult("zero_a",   32'h00000000, 32'h0000FFFF, 64'h0000000000000000, 1'b0, 1'b0, 1'b0);
        do_mult("hi_by_lo", 32'h00010000, 32'h00000003, 64'h0000000000030000, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
